volcano_name_rx: RTL
====================

# volcano_name_rx

Receive-side counterpart of the volcano-name ASCII streamer. It accepts one ASCII byte per qualified clock and matches each space-delimited word against the six fixed names. For each recognised word it reports a name index. It also checks that names arrive in the streamer's emission order, so a second chip or the test harness can check the transmitted sequence byte for byte.

## Interface
Parameters:
- `NAME_COUNT`, default 6: number of names in the ROM. Fixed; do not override.
- `MAX_LEN`, default 11: longest name in characters ("Santa Maria").

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset; **one clock; reset is synchronous and active-high** (high = reset; the port keeps the codebase name).
- `ena`, input, 1: block enable; when low, input bytes are ignored and state holds.
- `char_in`, input, 8: ASCII byte.
- `char_valid`, input, 1: `char_in` is accepted on a rising edge when `char_valid && ena`.
- `match_valid`, output, 1: one-cycle pulse when a word matched a name.
- `match_id`, output, 3: index of the last matched name; held until the next match.
- `miss`, output, 1: one-cycle pulse when a non-empty word matched no name.
- `seq_err`, output, 1: one-cycle pulse, coincident with `match_valid`, when `match_id` differs from the expected next index.
- `match_count`, output, 8: number of matches, saturating at 255.

## Operation
- Name ROM, indices 0–5: "Tajumulco", "Tacana", "Acatenango", "Fuego", "Santa Maria", "Agua". The ROM is combinational, addressed by (id, pos).
- State:
  - `alive[5:0]`: candidate mask, reset value all ones.
  - `pos[3:0]`: character position, reset value 0, saturates at 15.
  - `expect_id[2:0]`: expected next index, reset value 0.
- Accepted non-space byte (not 0x20):
  - `alive[i]` is cleared if `pos >= len(i)` or `char_in != ROM[i][pos]`.
  - `pos` increments (saturating).
- Accepted space (0x20), evaluated in this priority order:
  1. `pos == 0` (leading or consecutive space): ignored, no pulse.
  2. `alive[4] && pos == 5`: the space is part of "Santa Maria". It is treated as a character matched against ROM[4][5]; all other candidates are cleared; `pos` increments.
  3. Exactly one `i` has `alive[i] && pos == len(i)`:
     - `match_valid` pulses; `match_id <= i`; `match_count` increments (saturating).
     - `seq_err` pulses if `i != expect_id`.
     - `expect_id <= (i == 5) ? 0 : i + 1`, so it resyncs on the received id.
  4. Otherwise: `miss` pulses.
  - Cases 1, 3 and 4 then reset `alive` to all ones and `pos` to 0.
- No two names are equal, so at most one candidate can complete at a given `pos`.
- An overlong word (`pos` reaches 12 or more) has every candidate dead and always ends in `miss`.
- Bytes other than space, including control characters and NUL, are ordinary characters.

## Timing
- `match_valid`, `miss` and `seq_err` are registered and are high for exactly the one cycle after the edge that accepted the terminating space.
- `match_id` and `match_count` update on that same edge.
- Throughput: one byte per cycle, with no back-pressure.
- `char_valid` may be continuously high.
- `ena` low freezes all state. Pulse outputs are driven 0 while frozen.
- Reset values: `match_valid` = 0, `miss` = 0, `seq_err` = 0, `match_id` = 0, `match_count` = 0, `alive` = all ones, `pos` = 0, `expect_id` = 0.
- Reset asserted in mid-word discards the partial word with no pulse.
- Reset and a valid byte on the same edge: reset wins.

## Configuration
- `VOLCANO_RX_CASE_FOLD_EN`
  - Defined: both bytes are case-folded before comparison; bytes 0x61–0x7A are compared with bit 5 cleared. "FUEGO" and "fuego" match index 3.
  - Undefined: comparison is exact and case-sensitive. "fuego" ends in `miss`.
  - The space handling is identical in both builds.

## Test plan
- Full stream: the exact six-name byte sequence, each name followed by 0x20, after reset.
  - Required: `match_valid` pulses with ids 0,1,2,3,4,5 in order; `seq_err` never asserts; `match_count` = 6; `miss` never asserts.
- Bytes "Fuego " straight after reset: `match_valid` with `match_id` = 3 and `seq_err` = 1. A following "Santa Maria " gives id 4 with `seq_err` = 0.
- Bytes "Tacan " then "Tajumulcoo ": two `miss` pulses, no `match_valid`, `match_count` stays 0.
- Bytes "  Agua" with `char_valid` high, followed by two cycles of `ena` = 0 (with `char_valid` still high on a space), then " " with `ena` = 1:
  - Required: no pulse during the `ena`-low cycles; then a single `match_valid` with id 5.
- Bytes "Acaten", then reset for one cycle, then "Agua ": no pulse from the aborted word; one `match_valid` with id 5 and `seq_err` = 1.
- Byte "fuego " in both builds: a match with id 3 only when `VOLCANO_RX_CASE_FOLD_EN` is defined, otherwise `miss`. Also 300 back-to-back "Agua " words: `match_count` saturates at 255.

Source files
------------

// File: rtl/volcano_name_rx.sv
// volcano_name_rx
//   Receive side of the volcano-name ASCII streamer. Bytes arrive one per
//   accepted clock. Each space-delimited word is matched against six fixed
//   names. A recognised word reports its index. The block also flags any name
//   that arrives out of the streamer's emission order.
//
//   Build option: VOLCANO_RX_CASE_FOLD_EN -- when defined, lower-case letters
//   are folded to upper case on both sides of the comparison.
//
// Ports
//   clk         : rising-edge clock
//   rst_n       : synchronous, active-HIGH reset (legacy name kept)
//   ena         : block enable; low freezes all state and zeroes the pulses
//   char_in     : ASCII byte
//   char_valid  : char_in is accepted when char_valid && ena
//   match_valid : one-cycle pulse, a word matched a name
//   match_id    : index of the last matched name, held between matches
//   miss        : one-cycle pulse, a non-empty word matched no name
//   seq_err     : one-cycle pulse with match_valid when the order is broken
//   match_count : matches seen, saturating at 255
module volcano_name_rx #(
    parameter int NAME_COUNT = 6,
    parameter int MAX_LEN    = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       match_valid,
    output logic [2:0] match_id,
    output logic       miss,
    output logic       seq_err,
    output logic [7:0] match_count
);

    localparam logic [7:0] SPACE = 8'h20;
    localparam int         SANTA = 4;   // the only name containing a space
    localparam int         SANTA_GAP = 5;  // position of that space

    // Names are left-justified and padded to MAX_LEN; padding is never
    // compared because a position at or beyond the length kills the candidate.
    localparam logic [8*MAX_LEN-1:0] NAME_ROM [NAME_COUNT] = '{
        "Tajumulco  ", "Tacana     ", "Acatenango ",
        "Fuego      ", "Santa Maria", "Agua       "
    };
    localparam logic [3:0] NAME_LEN [NAME_COUNT] = '{
        4'd9, 4'd6, 4'd10, 4'd5, 4'd11, 4'd4
    };

    function automatic logic [7:0] rom_char(input int id, input logic [3:0] p);
        if (int'(p) >= MAX_LEN) return 8'h00;
        return NAME_ROM[id][8*(MAX_LEN-1-int'(p)) +: 8];
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef VOLCANO_RX_CASE_FOLD_EN
        return (b >= 8'h61 && b <= 8'h7A) ? (b & 8'hDF) : b;
`else
        return b;
`endif
    endfunction

    logic [NAME_COUNT-1:0] alive;
    logic [3:0]            pos;
    logic [2:0]            expect_id;
    logic                  match_q, miss_q, seq_err_q;

    logic [NAME_COUNT-1:0] char_ok;   // candidate survives this byte
    logic [NAME_COUNT-1:0] done;      // candidate complete at this position
    logic [2:0]            done_id;
    logic                  one_done;
    logic [3:0]            pos_inc;

    always_comb begin
        char_ok = '0;
        done    = '0;
        done_id = '0;
        for (int i = 0; i < NAME_COUNT; i++) begin
            char_ok[i] = (pos < NAME_LEN[i]) &&
                         (fold(rom_char(i, pos)) == fold(char_in));
            done[i]    = alive[i] && (pos == NAME_LEN[i]);
            if (done[i]) done_id = 3'(i);
        end
        one_done = (done != '0) && ((done & (done - 1'b1)) == '0);
        pos_inc  = (pos == 4'hF) ? pos : pos + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            alive       <= '1;
            pos         <= '0;
            expect_id   <= '0;
            match_q     <= 1'b0;
            miss_q      <= 1'b0;
            seq_err_q   <= 1'b0;
            match_id    <= '0;
            match_count <= '0;
        end else begin
            match_q   <= 1'b0;
            miss_q    <= 1'b0;
            seq_err_q <= 1'b0;
            if (ena && char_valid) begin
                if (char_in != SPACE) begin
                    alive <= alive & char_ok;
                    pos   <= pos_inc;
                end else if (pos == 4'd0) begin
                    // leading or repeated space: nothing to terminate
                end else if (alive[SANTA] && pos == 4'(SANTA_GAP)) begin
                    // inner space of "Santa Maria" keeps only that candidate
                    alive        <= '0;
                    alive[SANTA] <= char_ok[SANTA];
                    pos          <= pos_inc;
                end else begin
                    if (one_done) begin
                        match_q   <= 1'b1;
                        match_id  <= done_id;
                        seq_err_q <= (done_id != expect_id);
                        expect_id <= (done_id == 3'(NAME_COUNT-1)) ? 3'd0
                                                                   : done_id + 3'd1;
                        if (match_count != 8'hFF) match_count <= match_count + 8'd1;
                    end else begin
                        miss_q <= 1'b1;
                    end
                    alive <= '1;
                    pos   <= '0;
                end
            end
        end
    end

    // pulses read as zero whenever the block is frozen
    assign match_valid = match_q   & ena;
    assign miss        = miss_q    & ena;
    assign seq_err     = seq_err_q & ena;

endmodule
